// File: rtl/lc3_data_mem_responder.sv
// rtl/lc3_data_mem_responder.sv - LC3 data-memory responder with programmable wait states
//
// Purpose:
//   The memory end of the LC3 data-memory interface. One request is captured
//   from the memaccess stage, held for WAIT_STATES cycles, then committed
//   (write) or answered (read) with a single-cycle complete_data pulse. The
//   responder then waits for data_en to drop so that a held request is never
//   serviced twice.
//
// Optional feature macro: DMEM_OOR_CHECK_EN
//   Defined   : a captured address with any bit above DEPTH_LOG2 set is out of
//               range. Such a read returns 16'hDEAD, such a write is dropped,
//               and oor_err sets at completion and stays set until reset.
//   Undefined : upper address bits are ignored (addresses alias modulo depth)
//               and oor_err is tied low.
//
// Ports:
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   data_en        request strobe, held by the initiator until completion
//   data_rd        1 = read, 0 = write (sampled with data_en)
//   data_addr      16-bit word address (sampled with data_en)
//   data_din       write data (sampled with data_en)
//   data_dout      read data, valid with complete_data, held until next read
//   complete_data  one-cycle completion pulse
//   busy           high while a request is in flight or awaiting release
//   load_en        backdoor write strobe
//   load_addr      backdoor write address
//   load_data      backdoor write data
//   oor_err        sticky out-of-range flag

module lc3_data_mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  data_en,
    input  logic                  data_rd,
    input  logic [15:0]           data_addr,
    input  logic [DATA_W-1:0]     data_din,
    output logic [DATA_W-1:0]     data_dout,
    output logic                  complete_data,
    output logic                  busy,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [DATA_W-1:0]     load_data,
    output logic                  oor_err
);

    localparam int                DEPTH         = 1 << DEPTH_LOG2;
    localparam logic [DATA_W-1:0] OOR_READ_DATA = DATA_W'(16'hDEAD);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_RELEASE
    } state_t;

    state_t                  state;
    logic [3:0]              count;
    logic                    rd_q;
    logic [DEPTH_LOG2-1:0]   addr_q;
    logic [DATA_W-1:0]       din_q;
    logic                    oor_q;

    logic [DATA_W-1:0]       mem [0:DEPTH-1];

    logic                    capture;
    logic                    enter_resp;
    logic                    addr_oor;
    logic                    rd_sel;
    logic                    oor_sel;
    logic [DEPTH_LOG2-1:0]   rd_addr;

    assign capture = (state == ST_IDLE) && data_en;

    // RESP is entered straight from capture when there are no wait states,
    // otherwise from WAIT once the countdown has reached its last cycle.
    assign enter_resp = (capture && (WAIT_STATES == 0)) ||
                        ((state == ST_WAIT) && (count <= 4'd1));

`ifdef DMEM_OOR_CHECK_EN
    assign addr_oor = |data_addr[15:DEPTH_LOG2];
`else
    logic unused_addr_hi;
    assign addr_oor       = 1'b0;
    assign unused_addr_hi = |data_addr[15:DEPTH_LOG2];
`endif

    // With zero wait states the read happens on the capture edge itself, so
    // the live request fields must be used instead of the latched copies.
    always_comb begin
        rd_sel  = rd_q;
        oor_sel = oor_q;
        rd_addr = addr_q;
        if (state == ST_IDLE) begin
            rd_sel  = data_rd;
            oor_sel = addr_oor;
            rd_addr = data_addr[DEPTH_LOG2-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            count         <= 4'd0;
            rd_q          <= 1'b0;
            addr_q        <= '0;
            din_q         <= '0;
            oor_q         <= 1'b0;
            data_dout     <= '0;
            complete_data <= 1'b0;
            busy          <= 1'b0;
`ifdef DMEM_OOR_CHECK_EN
            oor_err       <= 1'b0;
`endif
        end else begin
            complete_data <= 1'b0;

            if (enter_resp) begin
                complete_data <= 1'b1;
                if (rd_sel) begin
                    data_dout <= oor_sel ? OOR_READ_DATA : mem[rd_addr];
                end
`ifdef DMEM_OOR_CHECK_EN
                if (oor_sel) begin
                    oor_err <= 1'b1;
                end
`endif
            end

            case (state)
                ST_IDLE: begin
                    if (data_en) begin
                        rd_q   <= data_rd;
                        addr_q <= data_addr[DEPTH_LOG2-1:0];
                        din_q  <= data_din;
                        oor_q  <= addr_oor;
                        count  <= 4'(WAIT_STATES);
                        busy   <= 1'b1;
                        state  <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (count <= 4'd1) begin
                        state <= ST_RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!data_en) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifndef DMEM_OOR_CHECK_EN
    assign oor_err = 1'b0;
`endif

    // Storage is not reset. The protocol write is placed after the backdoor
    // load so that it wins when both hit the same word on the same edge.
    always_ff @(posedge clock) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
        if ((state == ST_RESP) && !rd_q && !oor_q) begin
            mem[addr_q] <= din_q;
        end
    end

endmodule
